// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit core, with a memory-wait watchdog.
// Strobes are Moore outputs of state+IR except ir_write/pc_increment; memory backpressure is mem_ready.
module multicycle_controller #(
  parameter int                  OPCODE_W   = 2,
  parameter logic [OPCODE_W-1:0] ALU_SUB_OP = OPCODE_W'(2'b10),
  parameter int                  CNT_W      = 16,
  parameter int                  TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [1:0]          instr_mode,
  input  logic [OPCODE_W-1:0] instr_opcode,
  output logic                ir_write,
  output logic                pc_increment,
  output logic                pc_write,
  output logic                mem_read,
  output logic                memory_write,
  output logic                register_write,
  output logic                memory_to_register,
  output logic                alu_negation,
  output logic                val_a_imm_selection,
  output logic                val_b_pc_selection,
  output logic                reg_num_shift,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired_count
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] MODE_BR  = 2'b00;
  localparam logic [1:0] MODE_LD  = 2'b01;
  localparam logic [1:0] MODE_ST  = 2'b10;
  localparam logic [1:0] MODE_ALU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          ir_mode;
  logic [OPCODE_W-1:0] ir_opcode;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_hit;
  logic                halt_enc;
  logic                in_instr;
  logic                retire;

  // The counter holds the number of cycles already waited, so the TIMEOUT-th waiting cycle sees TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign halt_enc    = (ir_mode == MODE_BR) && (ir_opcode == '1);
  assign in_instr    = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
  assign retire      = (state_nxt == S_FETCH) &&
                       ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      ir_mode       <= '0;
      ir_opcode     <= '0;
      wait_cnt      <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_FETCH) && mem_ready) begin
        ir_mode   <= instr_mode;
        ir_opcode <= instr_opcode;
      end
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready && (TIMEOUT != 0)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (retire) begin
        retired_count <= retired_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt           = state;
    ir_write            = 1'b0;
    pc_increment        = 1'b0;
    pc_write            = 1'b0;
    mem_read            = 1'b0;
    memory_write        = 1'b0;
    register_write      = 1'b0;
    memory_to_register  = 1'b0;
    alu_negation        = 1'b0;
    val_a_imm_selection = in_instr && (ir_mode != MODE_ALU);
    val_b_pc_selection  = in_instr && (ir_mode == MODE_BR);
    reg_num_shift       = in_instr && ((ir_mode == MODE_LD) || (ir_mode == MODE_ST));
    halted              = (state == S_HALT);
    fault               = (state == S_FAULT);

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_read     = 1'b1;
        ir_write     = mem_ready;
        pc_increment = mem_ready;
        if (mem_ready)        state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        state_nxt = halt_enc ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_negation = (ir_mode == MODE_ALU) && (ir_opcode == ALU_SUB_OP);
        case (ir_mode)
          MODE_BR: begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end
          MODE_ALU: state_nxt = S_WB;
          default:  state_nxt = S_MEM;
        endcase
      end
      S_MEM: begin
        mem_read     = (ir_mode == MODE_LD);
        memory_write = (ir_mode == MODE_ST);
        if (mem_ready)        state_nxt = (ir_mode == MODE_ST) ? S_FETCH : S_WB;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_WB: begin
        register_write     = (ir_mode == MODE_LD) || ((ir_mode == MODE_ALU) && (ir_opcode != '0));
        memory_to_register = (ir_mode == MODE_LD);
        state_nxt          = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      S_FAULT: state_nxt = S_FAULT;
    endcase
  end

endmodule
